// File: rtl/apb_slave_regs_pkg.sv
// apb_slave_regs_pkg: shared APB widths, FSM state encoding and wait-counter width
package apb_slave_regs_pkg;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_WAIT_CNT_WIDTH = 4;
  typedef enum logic [1:0] {
    APB_S_IDLE   = 2'd0,
    APB_S_SETUP  = 2'd1,
    APB_S_ACCESS = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb_slave_fsm.sv
// apb_slave_fsm: APB transfer phase tracking, wait-state counting and pready generation
module apb_slave_fsm import apb_slave_regs_pkg::*; #(
  parameter int WAIT_STATES = 1
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic                          psel,
  input  logic                          penable,
  output apb_state_e                    state,
  output logic [APB_WAIT_CNT_WIDTH-1:0] cnt,
  output logic                          pready,
  output logic                          access_done,
  output logic                          violation
);
  localparam logic [APB_WAIT_CNT_WIDTH-1:0] WS = APB_WAIT_CNT_WIDTH'(WAIT_STATES);
  apb_state_e state_q, state_d;
  logic [APB_WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  // state_q holds the phase expected for the current cycle; the bus decides SETUP/abort live
  always_comb begin
    violation = psel & penable & (state_q == APB_S_IDLE);
    state = !psel ? APB_S_IDLE : !penable ? APB_S_SETUP : violation ? APB_S_IDLE : APB_S_ACCESS;
    access_done = (state == APB_S_ACCESS) & (cnt_q == WS);
    pready = access_done | violation;
    state_d = (state == APB_S_SETUP || (state == APB_S_ACCESS && !access_done)) ? APB_S_ACCESS : APB_S_IDLE;
    cnt_d = (state != APB_S_ACCESS) ? '0 : (cnt_q != WS) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= APB_S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer with byte-strobed RW register file and read-only ID register
module apb_slave_regs import apb_slave_regs_pkg::*; #(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NB = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
  logic [DATA_WIDTH-1:0] view [NUM_REGS];
  logic [IDX_W-1:0] idx;
  logic err, we, access_done, violation;
  apb_state_e state;
  logic [APB_WAIT_CNT_WIDTH-1:0] cnt;
  apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .state(state),
    .cnt(cnt), .pready(pready), .access_done(access_done), .violation(violation)
  );
  assign idx = paddr[IDX_W+1:2];
  // a setup-less access is reported as an error so it can never write or return data
  assign err = (|paddr[1:0]) | (|paddr[ADDR_WIDTH-1:IDX_W+2])
             | (pwrite & (idx == IDX_W'(NUM_REGS-1))) | violation;
  assign we = access_done & pwrite & ~err;
  assign pslverr = pready & err;
  assign prdata = (pready & ~pwrite & ~err) ? view[idx] : '0;
  always_comb begin
    for (int i = 0; i < NUM_REGS-1; i++) view[i] = regs_q[i];
    view[NUM_REGS-1] = ID_VALUE;
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = view[i];
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < NUM_REGS-1; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS-1; i++)
        for (int b = 0; b < NB; b++)
          if (idx == IDX_W'(i) && pstrb[b]) regs_q[i][8*b +: 8] <= pwdata[8*b +: 8];
    end
  end
  assert property (@(posedge hclk) disable iff (hreset) access_done |-> cnt == APB_WAIT_CNT_WIDTH'(WAIT_STATES));
  assert property (@(posedge hclk) disable iff (hreset) pready |-> (state == APB_S_ACCESS) || violation);
endmodule
